sipo_word_receiver: RTL and testbench

- Serial-in, parallel-out receiver: the receiving end of the team's parallel-load shift-register serial link.
- Collects framed serial bits into WIDTH-bit words and presents each word on a valid/ready parallel output with a single-entry holding register.
- Reports frame and overrun errors.
- Sits between the serial link and the downstream parallel consumer.

---
 rtl/sipo_word_receiver.sv | 143 ++++++++++++++
 tb/tb_sipo_word_receiver.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sipo_word_receiver.sv
// Serial-in/parallel-out word receiver: framed serial bits -> WIDTH-bit words on a valid/ready register.
// Latency 1 cycle from last bit to out_valid; a full, unconsumed output register drops new words (sticky overrun).
// Optional even parity bit per word when SIPO_PARITY_EN is defined.
module sipo_word_receiver #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             serial_in,
    input  logic             serial_valid,
    input  logic             sof,
    output logic [WIDTH-1:0] parallel_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             frame_err,
    output logic             overrun,
    output logic             parity_err
);

`ifdef SIPO_PARITY_EN
    localparam int LAST = WIDTH + 1;
`else
    localparam int LAST = WIDTH;
`endif
    localparam int CW = $clog2(WIDTH + 2);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    localparam logic [CW-1:0] DATA_C = CW'(WIDTH);
    localparam logic [CW-1:0] END_C  = CW'(LAST - 1);

    logic [0:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic             par_q, par_d;
    logic [WIDTH-1:0] pout_q, pout_d;
    logic             ovld_q, ovld_d;
    logic             ferr_q, ferr_d;
    logic             perr_q, perr_d;
    logic             ovr_q, ovr_d;
    logic             word_done;
    logic             word_ok;

    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] v, input logic b);
        if (MSB_FIRST) begin
            return {v[WIDTH-2:0], b};
        end else begin
            return {b, v[WIDTH-1:1]};
        end
    endfunction

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sr_d      = sr_q;
        par_d     = par_q;
        pout_d    = pout_q;
        ovld_d    = ovld_q;
        ovr_d     = ovr_q;
        ferr_d    = 1'b0;
        perr_d    = 1'b0;
        word_done = 1'b0;
        word_ok   = 1'b1;

        if (serial_valid) begin
            if (sof) begin
                // sof always restarts; only a partial word in flight is an error
                if (state_q == S_SHIFT && cnt_q != '0) begin
                    ferr_d = 1'b1;
                end
                state_d = S_SHIFT;
                cnt_d   = CW'(1);
                sr_d    = shift_in('0, serial_in);
                par_d   = serial_in;
            end else if (state_q == S_SHIFT) begin
                if (cnt_q < DATA_C) begin
                    sr_d  = shift_in(sr_q, serial_in);
                    par_d = par_q ^ serial_in;
                end
                if (cnt_q == END_C) begin
                    word_done = 1'b1;
                    cnt_d     = '0;
`ifdef SIPO_PARITY_EN
                    word_ok   = (par_q == serial_in);
`endif
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end

        perr_d = word_done & ~word_ok;

        // The holding register frees up in the same cycle it is consumed
        if (word_done && word_ok) begin
            if (!ovld_q || out_ready) begin
                pout_d = sr_d;
                ovld_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (ovld_q && out_ready) begin
            ovld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            par_q   <= 1'b0;
            pout_q  <= '0;
            ovld_q  <= 1'b0;
            ferr_q  <= 1'b0;
            perr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            par_q   <= par_d;
            pout_q  <= pout_d;
            ovld_q  <= ovld_d;
            ferr_q  <= ferr_d;
            perr_q  <= perr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign parallel_out = pout_q;
    assign out_valid    = ovld_q;
    assign frame_err    = ferr_q;
    assign overrun      = ovr_q;
`ifdef SIPO_PARITY_EN
    assign parity_err   = perr_q;
`else
    assign parity_err   = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_word_receiver.sv
// Directed bench for sipo_word_receiver: one MSB-first and one LSB-first instance share the serial stimulus.
module tb_sipo_word_receiver;

    logic       clk = 1'b0;
    logic       rst;
    logic       serial_in;
    logic       serial_valid;
    logic       sof;
    logic       out_ready;
    logic [3:0] po_m, po_l;
    logic       ov_m, ov_l, fe_m, fe_l, or_m, or_l, pe_m, pe_l;

    int   checks   = 0;
    int   failures = 0;
    int   fe_cnt   = 0;
    int   pe_cnt   = 0;
    int   wcnt     = 0;
    logic ov_prev  = 1'b0;

    always #5 clk = ~clk;

    sipo_word_receiver #(.WIDTH(4), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst), .serial_in(serial_in), .serial_valid(serial_valid), .sof(sof),
        .parallel_out(po_m), .out_valid(ov_m), .out_ready(out_ready),
        .frame_err(fe_m), .overrun(or_m), .parity_err(pe_m)
    );

    sipo_word_receiver #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .serial_in(serial_in), .serial_valid(serial_valid), .sof(sof),
        .parallel_out(po_l), .out_valid(ov_l), .out_ready(out_ready),
        .frame_err(fe_l), .overrun(or_l), .parity_err(pe_l)
    );

    // Pulse and new-word counters for the MSB-first instance
    always @(negedge clk) begin
        if (fe_m === 1'b1) fe_cnt++;
        if (pe_m === 1'b1) pe_cnt++;
        if (ov_m === 1'b1 && ov_prev !== 1'b1) wcnt++;
        ov_prev = ov_m;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic s, input int gap);
        repeat (gap) tick();
        serial_in    = b;
        sof          = s;
        serial_valid = 1'b1;
        tick();
        serial_valid = 1'b0;
        sof          = 1'b0;
        serial_in    = 1'b0;
    endtask

    // bits[3] goes out first; rdy_last raises out_ready just before the final bit
    task automatic send_word(input logic [3:0] bits, input logic s, input int gap, input logic rdy_last);
        for (int i = 3; i >= 0; i--) begin
`ifndef SIPO_PARITY_EN
            if (i == 0 && rdy_last) out_ready = 1'b1;
`endif
            send_bit(bits[i], (i == 3) ? s : 1'b0, (i == 3) ? 0 : gap);
        end
`ifdef SIPO_PARITY_EN
        if (rdy_last) out_ready = 1'b1;
        send_bit(^bits, 1'b0, gap);
`endif
    endtask

    task automatic do_reset();
        rst          = 1'b0;
        serial_valid = 1'b0;
        sof          = 1'b0;
        serial_in    = 1'b0;
        out_ready    = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; serial_valid = 1'b1; sof = 1'b1; serial_in = 1'b1; out_ready = 1'b1;
        repeat (2) tick();
        checks++; if (ov_m !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", ov_m); end
        checks++; if (po_m !== 4'b0000) begin failures++; $display("FAIL reset_parallel_out got=%b exp=0000", po_m); end
        checks++; if (fe_m !== 1'b0) begin failures++; $display("FAIL reset_frame_err got=%b exp=0", fe_m); end
        checks++; if (or_m !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", or_m); end
        checks++; if (pe_m !== 1'b0) begin failures++; $display("FAIL reset_parity_err got=%b exp=0", pe_m); end
        checks++; if (po_l !== 4'b0000) begin failures++; $display("FAIL reset_lsb_parallel_out got=%b exp=0000", po_l); end
        serial_valid = 1'b0; sof = 1'b0; serial_in = 1'b0; out_ready = 1'b0;
    endtask

    task automatic test_basic();
        do_reset();
        out_ready = 1'b1;
        send_word(4'b1101, 1'b1, 0, 1'b0);
        checks++; if (ov_m !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b exp=1", ov_m); end
        checks++; if (po_m !== 4'b1101) begin failures++; $display("FAIL basic_word got=%b exp=1101", po_m); end
        checks++; if (po_l !== 4'b1011) begin failures++; $display("FAIL basic_lsb_word got=%b exp=1011", po_l); end
        tick();
        checks++; if (ov_m !== 1'b0) begin failures++; $display("FAIL basic_consumed got=%b exp=0", ov_m); end
        checks++; if (po_m !== 4'b1101) begin failures++; $display("FAIL basic_hold_word got=%b exp=1101", po_m); end
        out_ready = 1'b0;
    endtask

    task automatic test_lsb_first();
        do_reset();
        out_ready = 1'b1;
        send_word(4'b1000, 1'b1, 0, 1'b0);
        checks++; if (ov_l !== 1'b1) begin failures++; $display("FAIL lsb_valid got=%b exp=1", ov_l); end
        checks++; if (po_l !== 4'b0001) begin failures++; $display("FAIL lsb_word got=%b exp=0001", po_l); end
        checks++; if (po_m !== 4'b1000) begin failures++; $display("FAIL lsb_msb_word got=%b exp=1000", po_m); end
        out_ready = 1'b0;
    endtask

    task automatic test_overrun();
        do_reset();
        send_word(4'b1101, 1'b1, 0, 1'b0);
        checks++; if (or_m !== 1'b0) begin failures++; $display("FAIL ovr_before got=%b exp=0", or_m); end
        send_word(4'b0100, 1'b0, 0, 1'b0);
        checks++; if (or_m !== 1'b1) begin failures++; $display("FAIL ovr_set got=%b exp=1", or_m); end
        checks++; if (po_m !== 4'b1101) begin failures++; $display("FAIL ovr_word_kept got=%b exp=1101", po_m); end
        checks++; if (ov_m !== 1'b1) begin failures++; $display("FAIL ovr_valid_kept got=%b exp=1", ov_m); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (ov_m !== 1'b0) begin failures++; $display("FAIL ovr_consume got=%b exp=0", ov_m); end
        checks++; if (or_m !== 1'b1) begin failures++; $display("FAIL ovr_sticky got=%b exp=1", or_m); end
    endtask

    task automatic test_frame_err();
        int f0, w0;
        do_reset();
        f0 = fe_cnt;
        w0 = wcnt;
        send_bit(1'b1, 1'b1, 0);
        send_bit(1'b1, 1'b0, 0);
        send_bit(1'b0, 1'b1, 0);
        checks++; if (fe_m !== 1'b1) begin failures++; $display("FAIL ferr_pulse got=%b exp=1", fe_m); end
        send_bit(1'b1, 1'b0, 0);
        checks++; if (fe_m !== 1'b0) begin failures++; $display("FAIL ferr_one_cycle got=%b exp=0", fe_m); end
        send_bit(1'b0, 1'b0, 0);
        send_bit(1'b0, 1'b0, 0);
`ifdef SIPO_PARITY_EN
        send_bit(1'b1, 1'b0, 0);
`endif
        checks++; if (ov_m !== 1'b1) begin failures++; $display("FAIL ferr_valid got=%b exp=1", ov_m); end
        checks++; if (po_m !== 4'b0100) begin failures++; $display("FAIL ferr_word got=%b exp=0100", po_m); end
        tick();
        checks++; if (fe_cnt - f0 !== 1) begin failures++; $display("FAIL ferr_count got=%0d exp=1", fe_cnt - f0); end
        checks++; if (wcnt - w0 !== 1) begin failures++; $display("FAIL ferr_words got=%0d exp=1", wcnt - w0); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        send_word(4'b1010, 1'b1, 3, 1'b0);
        checks++; if (ov_m !== 1'b1) begin failures++; $display("FAIL gap_valid got=%b exp=1", ov_m); end
        checks++; if (po_m !== 4'b1010) begin failures++; $display("FAIL gap_word got=%b exp=1010", po_m); end
        send_word(4'b0110, 1'b0, 0, 1'b1);
        out_ready = 1'b0;
        checks++; if (po_m !== 4'b0110) begin failures++; $display("FAIL b2b_word got=%b exp=0110", po_m); end
        checks++; if (ov_m !== 1'b1) begin failures++; $display("FAIL b2b_valid got=%b exp=1", ov_m); end
        checks++; if (or_m !== 1'b0) begin failures++; $display("FAIL b2b_no_overrun got=%b exp=0", or_m); end
        tick();
        checks++; if (ov_m !== 1'b1 || po_m !== 4'b0110) begin
            failures++; $display("FAIL b2b_stable got=%b/%b exp=1/0110", ov_m, po_m);
        end
    endtask

    task automatic test_reset_mid();
        int w0;
        do_reset();
        send_word(4'b1101, 1'b1, 0, 1'b0);
        send_bit(1'b1, 1'b1, 0);
        send_bit(1'b0, 1'b0, 0);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            serial_valid = 1'b1;
            serial_in    = 1'b1;
            tick();
            checks++; if (ov_m !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%b exp=0", ov_m); end
        end
        serial_valid = 1'b0;
        serial_in    = 1'b0;
        rst          = 1'b1;
        w0           = wcnt;
        send_word(4'b0111, 1'b1, 0, 1'b0);
        checks++; if (ov_m !== 1'b1) begin failures++; $display("FAIL rstmid_out_valid got=%b exp=1", ov_m); end
        checks++; if (po_m !== 4'b0111) begin failures++; $display("FAIL rstmid_word got=%b exp=0111", po_m); end
        tick();
        checks++; if (wcnt - w0 !== 1) begin failures++; $display("FAIL rstmid_words got=%0d exp=1", wcnt - w0); end
    endtask

    task automatic test_parity();
`ifdef SIPO_PARITY_EN
        do_reset();
        out_ready = 1'b1;
        send_bit(1'b1, 1'b1, 0);
        send_bit(1'b1, 1'b0, 0);
        send_bit(1'b0, 1'b0, 0);
        send_bit(1'b1, 1'b0, 0);
        send_bit(1'b0, 1'b0, 0);
        checks++; if (pe_m !== 1'b1) begin failures++; $display("FAIL par_err_pulse got=%b exp=1", pe_m); end
        checks++; if (ov_m !== 1'b0) begin failures++; $display("FAIL par_no_output got=%b exp=0", ov_m); end
        tick();
        checks++; if (pe_m !== 1'b0) begin failures++; $display("FAIL par_err_one_cycle got=%b exp=0", pe_m); end
        send_bit(1'b1, 1'b1, 0);
        send_bit(1'b1, 1'b0, 0);
        send_bit(1'b0, 1'b0, 0);
        send_bit(1'b1, 1'b0, 0);
        send_bit(1'b1, 1'b0, 0);
        checks++; if (ov_m !== 1'b1 || po_m !== 4'b1101) begin
            failures++; $display("FAIL par_good_word got=%b/%b exp=1/1101", ov_m, po_m);
        end
        checks++; if (or_m !== 1'b0) begin failures++; $display("FAIL par_overrun got=%b exp=0", or_m); end
        out_ready = 1'b0;
`else
        tick();
        checks++; if (pe_cnt !== 0) begin failures++; $display("FAIL par_tied_low got=%0d pulses exp=0", pe_cnt); end
`endif
    endtask

    initial begin
        rst          = 1'b0;
        serial_in    = 1'b0;
        serial_valid = 1'b0;
        sof          = 1'b0;
        out_ready    = 1'b0;
        test_reset();
        test_basic();
        test_lsb_first();
        test_overrun();
        test_frame_err();
        test_back_to_back();
        test_reset_mid();
        test_parity();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
